// File: rtl/wt_seq_pkg.sv
// Shared types for the weight load sequencer.
// State encoding and default widths.
package wt_seq_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LUT_START,
    S_LUT_RUN,
    S_FLUSH_L,
    S_WT_START,
    S_WT_RUN,
    S_FLUSH_W,
    S_ABORT,
    S_DONE
  } wt_seq_state_t;

endpackage

// File: rtl/weight_load_sequencer_counter.sv
// Beat counter shared by the LUT and weight phases.
// clr/en/load/limit in, last = (count == limit-1) out.
module wt_beat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] limit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      limit_q <= '0;
    end else begin
      if (clr) begin
        count_q <= '0;
      end else if (en) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (load) begin
        limit_q <= limit;
      end
    end
  end

  // compare uses the pre-increment count
  assign last = (count_q == (limit_q - CNT_W'(1)));

endmodule

// File: rtl/weight_load_sequencer.sv
// Job controller for weight_dispatcher: optional LUT phase then weight phase.
// Ports: job descriptor in, dispatcher ctrl/handshake, PE handshake, status.
module weight_load_sequencer
  import wt_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic              job_lut_en,
  input  logic [ADDR_W-1:0] job_lut_base,
  input  logic [CNT_W-1:0]  job_lut_words,
  input  logic [ADDR_W-1:0] job_wt_base,
  input  logic [CNT_W-1:0]  job_wt_tiles,
  input  logic              abort,
  output logic              disp_start,
  output logic [ADDR_W-1:0] disp_base_addr,
  output logic              disp_update_lut,
  output logic              disp_flush,
  input  logic              disp_out_valid,
  output logic              disp_out_ready,
  output logic              pe_valid,
  input  logic              pe_ready,
  output logic              busy,
  output logic              job_done,
  output logic              job_aborted
);

  wt_seq_state_t state_q, state_d;

  logic [ADDR_W-1:0] wt_base_q;
  logic [CNT_W-1:0]  lut_words_q;
  logic [CNT_W-1:0]  wt_tiles_q;
  logic              aborted_q;

  logic              accept;
  logic              lut_go;
  logic              wt_go;
  logic              hs;
  logic              last;
  logic              cnt_clr;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_limit;

  assign accept = job_valid && job_ready;
  assign lut_go = job_lut_en && (job_lut_words != '0);
  assign wt_go  = !lut_go && (job_wt_tiles != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_base_q      <= '0;
      lut_words_q    <= '0;
      wt_tiles_q     <= '0;
      disp_base_addr <= '0;
      aborted_q      <= 1'b0;
      job_done       <= 1'b0;
      job_aborted    <= 1'b0;
    end else begin
      if (accept) begin
        wt_base_q   <= job_wt_base;
        lut_words_q <= job_lut_words;
        wt_tiles_q  <= job_wt_tiles;
        if (lut_go) begin
          disp_base_addr <= job_lut_base;
        end else if (wt_go) begin
          disp_base_addr <= job_wt_base;
        end
      end else if (state_q == S_FLUSH_L) begin
        disp_base_addr <= wt_base_q;
      end
      if (state_q == S_IDLE) begin
        aborted_q <= 1'b0;
      end else if (state_q == S_ABORT) begin
        aborted_q <= 1'b1;
      end
      job_done    <= (state_q == S_DONE);
      job_aborted <= (state_q == S_DONE) && aborted_q;
    end
  end

  always_comb begin
    state_d         = state_q;
    job_ready       = 1'b0;
    disp_start      = 1'b0;
    disp_update_lut = 1'b0;
    disp_flush      = 1'b0;
    disp_out_ready  = 1'b0;
    pe_valid        = 1'b0;
    hs              = 1'b0;
    cnt_load        = 1'b0;
    cnt_limit       = wt_tiles_q;
    unique case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          unique case (1'b1)
            lut_go:  state_d = S_LUT_START;
            wt_go:   state_d = S_WT_START;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_LUT_START: begin
        disp_start      = 1'b1;
        disp_update_lut = 1'b1;
        cnt_load        = 1'b1;
        cnt_limit       = lut_words_q;
        state_d         = abort ? S_ABORT : S_LUT_RUN;
      end
      S_LUT_RUN: begin
        disp_update_lut = 1'b1;
        disp_out_ready  = 1'b1;
        hs              = disp_out_valid;
        if (abort) begin
          state_d = S_ABORT;
        end else if (hs && last) begin
          state_d = S_FLUSH_L;
        end
      end
      S_FLUSH_L: begin
        disp_flush = 1'b1;
        state_d    = (wt_tiles_q != '0) ? S_WT_START : S_DONE;
      end
      S_WT_START: begin
        disp_start = 1'b1;
        cnt_load   = 1'b1;
        state_d    = abort ? S_ABORT : S_WT_RUN;
      end
      S_WT_RUN: begin
        pe_valid       = disp_out_valid;
        disp_out_ready = pe_ready;
        hs             = disp_out_valid && pe_ready;
        if (abort) begin
          state_d = S_ABORT;
        end else if (hs && last) begin
          state_d = S_FLUSH_W;
        end
      end
      S_FLUSH_W: begin
        disp_flush = 1'b1;
        state_d    = S_DONE;
      end
      S_ABORT: begin
        disp_flush = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign cnt_clr = (state_q != S_LUT_RUN) && (state_q != S_WT_RUN);

  wt_beat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (hs),
    .load (cnt_load),
    .limit(cnt_limit),
    .last (last)
  );

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Self-checking bench for weight_load_sequencer.
// Dispatcher model plus address scoreboards for LUT and PE beats.
module tb_weight_load_sequencer;

  logic       clk;
  logic       rst_n;
  logic       job_valid;
  logic       job_ready;
  logic       job_lut_en;
  logic [7:0] job_lut_base;
  logic [7:0] job_lut_words;
  logic [7:0] job_wt_base;
  logic [7:0] job_wt_tiles;
  logic       abort;
  logic       disp_start;
  logic [7:0] disp_base_addr;
  logic       disp_update_lut;
  logic       disp_flush;
  logic       disp_out_valid;
  logic       disp_out_ready;
  logic       pe_valid;
  logic       pe_ready;
  logic       busy;
  logic       job_done;
  logic       job_aborted;

  weight_load_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_lut_en     (job_lut_en),
    .job_lut_base   (job_lut_base),
    .job_lut_words  (job_lut_words),
    .job_wt_base    (job_wt_base),
    .job_wt_tiles   (job_wt_tiles),
    .abort          (abort),
    .disp_start     (disp_start),
    .disp_base_addr (disp_base_addr),
    .disp_update_lut(disp_update_lut),
    .disp_flush     (disp_flush),
    .disp_out_valid (disp_out_valid),
    .disp_out_ready (disp_out_ready),
    .pe_valid       (pe_valid),
    .pe_ready       (pe_ready),
    .busy           (busy),
    .job_done       (job_done),
    .job_aborted    (job_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // dispatcher model: parks on a prefetched beat, flush drops it
  logic       dm_valid;
  logic [7:0] dm_addr;
  assign disp_out_valid = dm_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_valid <= 1'b0;
      dm_addr  <= 8'h00;
    end else if (disp_flush) begin
      dm_valid <= 1'b0;
    end else if (disp_start) begin
      dm_valid <= 1'b1;
      dm_addr  <= disp_base_addr;
    end else if (dm_valid && disp_out_ready) begin
      dm_addr <= dm_addr + 8'd1;
    end
  end

  logic [8:0] lut_q[$];
  logic [8:0] pe_q[$];
  int starts  = 0;
  int flushes = 0;
  int dones   = 0;
  int lut_n   = 0;
  int pe_n    = 0;
  int upd_cyc = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (disp_out_valid && disp_out_ready && disp_update_lut) begin
        e = (lut_q.size() > 0) ? lut_q.pop_front() : 9'h1ff;
        chk("lut_addr", {1'b0, dm_addr}, e);
        chk("lut_no_pe", pe_valid, 0);
        lut_n++;
      end
      if (pe_valid && pe_ready) begin
        e = (pe_q.size() > 0) ? pe_q.pop_front() : 9'h1ff;
        chk("pe_addr", {1'b0, dm_addr}, e);
        pe_n++;
      end
      if (disp_start) starts++;
      if (disp_flush) flushes++;
      if (job_done) dones++;
      if (disp_update_lut) upd_cyc++;
    end
  end

  bit tog = 0;
  initial begin
    pe_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pe_ready = tog ? ~pe_ready : 1'b1;
    end
  end

  task automatic run_job(input string tag, input bit le,
                         input logic [7:0] lb, input logic [7:0] lw,
                         input logic [7:0] wb, input logic [7:0] wt,
                         input int abort_at, input int exp_pe,
                         input bit exp_ab, input int exp_cyc);
    int s0, f0, d0, l0, p0, u0, cyc, exp_st;
    bit got, ab_done;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      if (le && i < int'(lw)) begin
        a = lb + 8'(i);
        lut_q.push_back({1'b0, a});
      end
    end
    for (int i = 0; i < exp_pe; i++) begin
      a = wb + 8'(i);
      pe_q.push_back({1'b0, a});
    end
    s0 = starts; f0 = flushes; d0 = dones;
    l0 = lut_n;  p0 = pe_n;    u0 = upd_cyc;
    exp_st = ((le && lw != 0) ? 1 : 0) + ((wt != 0) ? 1 : 0);
    job_valid     = 1'b1;
    job_lut_en    = le;
    job_lut_base  = lb;
    job_lut_words = lw;
    job_wt_base   = wb;
    job_wt_tiles  = wt;
    cyc = 0;
    while (!job_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    @(posedge clk); #1;
    job_valid = 1'b0;
    cyc = 1;
    got = 0;
    ab_done = 0;
    chk({tag, "_start_lat"}, disp_start, (exp_st != 0) ? 1 : 0);
    while (!got && cyc < 300) begin
      abort = 1'b0;
      if (job_done) begin
        got = 1;
        chk({tag, "_aborted"}, job_aborted, exp_ab);
        if (exp_cyc > 0) chk({tag, "_done_cyc"}, cyc, exp_cyc);
      end else begin
        if (abort_at > 0 && !ab_done && pe_n - p0 == abort_at) begin
          abort = 1'b1;
          ab_done = 1;
        end
        @(posedge clk); #1; cyc++;
      end
    end
    abort = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    @(posedge clk); #1;
    chk({tag, "_lut_beats"}, lut_n - l0, le ? int'(lw) : 0);
    chk({tag, "_pe_beats"}, pe_n - p0, exp_pe);
    chk({tag, "_starts"}, starts - s0, exp_st);
    chk({tag, "_flushes"}, flushes - f0, exp_st);
    chk({tag, "_dones"}, dones - d0, 1);
    chk({tag, "_q_left"}, lut_q.size() + pe_q.size(), 0);
    if (!le) chk({tag, "_no_upd"}, upd_cyc - u0, 0);
    lut_q.delete();
    pe_q.delete();
  endtask

  initial begin
    int l0, d0, n;
    rst_n = 1'b0;
    job_valid = 1'b0;
    job_lut_en = 1'b0;
    job_lut_base = '0;
    job_lut_words = '0;
    job_wt_base = '0;
    job_wt_tiles = '0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_base", disp_base_addr, 0);
    chk("rst_start", disp_start, 0);
    chk("rst_done", job_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job("lutwt", 1, 8'h10, 8'd2, 8'h20, 8'd3, 0, 3, 0, 0);

    tog = 1;
    run_job("bp", 0, 8'h00, 8'd5, 8'h30, 8'd4, 0, 4, 0, 0);
    tog = 0;
    @(posedge clk); #1;

    run_job("empty", 1, 8'h00, 8'd0, 8'h00, 8'd0, 0, 0, 0, 2);

    run_job("abort", 0, 8'h00, 8'd0, 8'h40, 8'd5, 2, 3, 1, 0);
    run_job("after", 0, 8'h00, 8'd0, 8'h50, 8'd2, 0, 2, 0, 0);

    for (int i = 0; i < 8; i++) lut_q.push_back(9'h060 + 9'(i));
    l0 = lut_n;
    d0 = dones;
    job_valid = 1'b1;
    job_lut_en = 1'b1;
    job_lut_base = 8'h60;
    job_lut_words = 8'd8;
    job_wt_base = 8'h70;
    job_wt_tiles = 8'd3;
    @(posedge clk); #1;
    job_valid = 1'b0;
    n = 0;
    while (lut_n - l0 < 2 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("rst_mid_inrun", disp_update_lut & disp_out_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_upd", disp_update_lut, 0);
    chk("rst_mid_ordy", disp_out_ready, 0);
    chk("rst_mid_base", disp_base_addr, 0);
    lut_q.delete();
    pe_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", job_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_nodone", dones - d0, 0);

    run_job("wrap", 0, 8'h00, 8'd0, 8'hFE, 8'd3, 0, 3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_load_sequencer.md
Name: weight_load_sequencer

Overview:
Job-level controller for weight_dispatcher. It accepts a load descriptor and runs it in up to two phases. The first is an optional LUT-programming phase: buffer words are streamed into the LUT bank and withheld from the PE array. The second is a weight-tile phase: beats stream to the PE array with exact beat counting. It drives the dispatcher's start, base-address, LUT-update and flush controls, and gates the dispatcher output handshake. It sits between the layer control FSM and weight_dispatcher.

Parameters:
ADDR_W, 8, weight buffer address width (matches dispatcher base address)
CNT_W, 8, width of the LUT-word and weight-tile beat counters

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  descriptor valid
job_ready  out  1  sequencer can accept a descriptor (high only in S_IDLE)
job_lut_en  in  1  run the LUT phase
job_lut_base  in  ADDR_W  first buffer address of the LUT words
job_lut_words  in  CNT_W  number of LUT beats
job_wt_base  in  ADDR_W  first buffer address of the weight tiles
job_wt_tiles  in  CNT_W  number of weight beats sent to the PE array
abort  in  1  abandon the current job
disp_start  out  1  one-cycle start pulse to the dispatcher
disp_base_addr  out  ADDR_W  base address for the dispatcher
disp_update_lut  out  1  LUT-update mode level to the dispatcher
disp_flush  out  1  one-cycle synchronous return-to-idle for the dispatcher
disp_out_valid  in  1  dispatcher output valid
disp_out_ready  out  1  gated ready to the dispatcher
pe_valid  out  1  weight beat valid to the PE array
pe_ready  in  1  PE array ready
busy  out  1  high whenever state is not S_IDLE
job_done  out  1  one-cycle completion pulse
job_aborted  out  1  qualifies job_done; 1 means the job ended by abort

Behaviour:
- Reset: state is S_IDLE and every registered output is 0. Both counters clear. disp_base_addr resets to 0. Reset mid-job drops the job silently, with no job_done.
- Descriptor acceptance: a descriptor is accepted when job_valid and job_ready are both high, and all fields are registered on that cycle. A descriptor arriving while busy waits on job_ready.
- Next state on acceptance:
  - go to S_LUT_START if lut_en is 1 and lut_words is not 0;
  - otherwise go to S_WT_START if wt_tiles is not 0;
  - otherwise go to S_DONE (an empty job).
- S_LUT_START (1 cycle): disp_start=1, disp_base_addr=lut_base, disp_update_lut=1. Next state is S_LUT_RUN.
- S_LUT_RUN:
  - disp_update_lut is held at 1, disp_out_ready=1 and pe_valid=0.
  - The beat counter increments on each disp_out_valid & disp_out_ready.
  - On the beat where count equals lut_words-1, go to S_FLUSH_L.
- S_FLUSH_L (1 cycle): disp_flush=1, disp_update_lut=0, disp_out_ready=0. The counter clears. Next state is S_WT_START if wt_tiles is not 0, otherwise S_DONE.
- S_WT_START (1 cycle): disp_start=1, disp_base_addr=wt_base, disp_update_lut=0. Next state is S_WT_RUN.
- S_WT_RUN:
  - pe_valid = disp_out_valid and disp_out_ready = pe_ready, both combinational.
  - The counter increments on pe_valid & pe_ready.
  - On the beat where count equals wt_tiles-1, go to S_FLUSH_W.
- S_FLUSH_W (1 cycle): disp_flush=1. Next state is S_DONE.
- S_DONE (1 cycle): job_done=1. Next state is S_IDLE.
- Ready gating: outside the two RUN states, disp_out_ready=0 and pe_valid=0. This makes the dispatcher park on its prefetched beat; the following disp_flush discards that beat.
- Beat counts are exact. Exactly lut_words beats go to the LUT and exactly wt_tiles beats reach the PE array. Buffer addresses run from base to base+N-1 and wrap modulo 2^ADDR_W; the sequencer does not check for wrap.
- Abort:
  - abort in any RUN or START state goes next cycle to S_ABORT: disp_flush=1, all readies 0. Next state is S_DONE with job_aborted=1.
  - A beat whose handshake completes in the same cycle as abort is counted and delivered; the abort still wins the transition.
  - abort in S_IDLE, S_DONE or a FLUSH state is ignored.
- Last-beat timing: the last-beat compare uses the pre-increment count. For N=1 the RUN state lasts exactly until the first handshake.
- Latency: from descriptor acceptance to disp_start is 1 cycle.

Decomposition:
- Shared package wt_seq_pkg: state encoding (S_IDLE, S_LUT_START, S_LUT_RUN, S_FLUSH_L, S_WT_START, S_WT_RUN, S_FLUSH_W, S_ABORT, S_DONE), default ADDR_W and CNT_W.
- One natural sub-module: wt_beat_counter (clear, enable, terminal-count compare against a loaded limit). It is instanced once and shared by both phases.

Test Plan:
- LUT and weights: lut_en=1, lut_base=0x10, lut_words=2, wt_base=0x20, wt_tiles=3, pe_ready=1 -> disp_update_lut high for exactly 2 beats (addresses 0x10, 0x11) with pe_valid=0; flush pulse; 3 pe beats (addresses 0x20 to 0x22); one job_done with job_aborted=0; total pe handshakes = 3.
- Weights only with backpressure: lut_en=0, wt_tiles=4, pe_ready toggling 1010 -> exactly 4 pe handshakes, no beat lost or duplicated, disp_update_lut never 1.
- Empty job: lut_en=1, lut_words=0, wt_tiles=0 -> no disp_start, job_done exactly 2 cycles after acceptance.
- Abort: abort in S_WT_RUN after 2 of 5 beats -> disp_flush pulse, job_done with job_aborted=1; the next job restarts cleanly at its own wt_base.
- Reset mid-run: assert rst_n=0 during S_LUT_RUN -> all outputs 0 in the same cycle, no job_done; job_ready=1 after release.
- Address wrap: wt_base=0xFE, wt_tiles=3 -> the dispatcher reads 0xFE, 0xFF, 0x00, and the sequencer still completes after 3 beats.
